// File: rtl/writeback_forward_unit.sv
// Tracks the M and W stages of a 5-stage pipeline, resolves EX operands and detects data hazards.
// Define WB_FWD_BYPASS_EN for full forwarding; otherwise the unit stalls until the register file holds the value.
module writeback_forward_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [31:0] ex_alu_result,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [31:0] mem_load_data,
    output logic [31:0] fwd_rs_data,
    output logic [31:0] fwd_rt_data,
    output logic        stall,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [15:0] stall_count
);

    logic [4:0]  m_rd_q, w_rd_q;
    logic        m_we_q, m_load_q, w_we_q;
    logic [31:0] m_result_q, w_data_q;
    logic [31:0] w_data_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        w_data_d      = m_load_q ? mem_load_data : m_result_q;
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Both stages advance every cycle; bubbling ID/EX during a stall is the surrounding pipeline's job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd_q        <= 5'd0;
            m_we_q        <= 1'b0;
            m_load_q      <= 1'b0;
            m_result_q    <= 32'd0;
            w_rd_q        <= 5'd0;
            w_we_q        <= 1'b0;
            w_data_q      <= 32'd0;
            stall_count_q <= 16'd0;
        end else begin
            m_rd_q        <= ex_rd;
            m_we_q        <= ex_reg_write;
            m_load_q      <= ex_mem_read;
            m_result_q    <= ex_alu_result;
            w_rd_q        <= m_rd_q;
            w_we_q        <= m_we_q;
            w_data_q      <= w_data_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign wb_we       = w_we_q && (w_rd_q != 5'd0);
    assign wb_addr     = w_rd_q;
    assign wb_data     = w_data_q;
    assign stall_count = stall_count_q;

`ifdef WB_FWD_BYPASS_EN
    // A load sitting in M has no data yet, so it never forwards; the youngest ALU result wins over W.
    function automatic logic [31:0] resolve(input logic [4:0] src, input logic [31:0] rf_val);
        logic [31:0] val;
        val = rf_val;
        if (src == 5'd0) begin
            val = rf_val;
        end else if (m_we_q && !m_load_q && m_rd_q == src) begin
            val = m_result_q;
        end else if (w_we_q && w_rd_q == src) begin
            val = w_data_q;
        end
        return val;
    endfunction

    assign fwd_rs_data = resolve(ex_rs, ex_rs_data);
    assign fwd_rt_data = resolve(ex_rt, ex_rt_data);
    assign stall = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (ex_rd == id_rt));
`else
    function automatic logic pending(input logic [4:0] src);
        return (src != 5'd0) &&
               ((ex_reg_write && ex_rd == src) ||
                (m_we_q && m_rd_q == src) ||
                (w_we_q && w_rd_q == src));
    endfunction

    logic unused_ok;
    assign unused_ok   = ^{ex_rs, ex_rt};
    assign fwd_rs_data = ex_rs_data;
    assign fwd_rt_data = ex_rt_data;
    assign stall       = pending(id_rs) || pending(id_rt);
`endif

endmodule

// File: tb/tb_writeback_forward_unit.sv
// Randomized and directed checks of writeback_forward_unit against a behavioural pipeline model.
// Honours WB_FWD_BYPASS_EN the same way the design does.
module tb_writeback_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ex_rd, ex_rs, ex_rt, id_rs, id_rt;
    logic        ex_reg_write, ex_mem_read;
    logic [31:0] ex_alu_result, ex_rs_data, ex_rt_data, mem_load_data;
    logic [31:0] fwd_rs_data, fwd_rt_data, wb_data;
    logic        stall, wb_we;
    logic [4:0]  wb_addr;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    writeback_forward_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_alu_result(ex_alu_result), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .mem_load_data(mem_load_data),
        .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data), .stall(stall),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall_count(stall_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Instruction history: hist[0] is one instruction behind EX (value = ALU result),
    // hist[1] is two behind (value = what goes to the register file).
    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic        load;
        logic [31:0] val;
    } instr_t;

    instr_t hist[2];
    int     model_cnt;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) hist[i] = '{rd: 5'd0, we: 1'b0, load: 1'b0, val: 32'd0};
        model_cnt = 0;
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] src, input logic [31:0] rf_val);
        if (src == 5'd0) return rf_val;
`ifdef WB_FWD_BYPASS_EN
        for (int i = 0; i < 2; i++) begin
            if (hist[i].we && hist[i].rd == src && !(i == 0 && hist[i].load)) return hist[i].val;
        end
`endif
        return rf_val;
    endfunction

    function automatic logic model_stall();
        logic [4:0] srcs[2];
        logic       s;
        srcs[0] = id_rs;
        srcs[1] = id_rt;
        s = 1'b0;
`ifdef WB_FWD_BYPASS_EN
        s = ex_mem_read && ex_reg_write && ex_rd != 5'd0 && (ex_rd == id_rs || ex_rd == id_rt);
`else
        for (int k = 0; k < 2; k++) begin
            if (srcs[k] != 5'd0) begin
                if (ex_reg_write && ex_rd == srcs[k]) s = 1'b1;
                for (int i = 0; i < 2; i++) if (hist[i].we && hist[i].rd == srcs[k]) s = 1'b1;
            end
        end
`endif
        return s;
    endfunction

    task automatic check_all(input string tag);
        check_val({tag, "_fwd_rs"}, fwd_rs_data, model_fwd(ex_rs, ex_rs_data));
        check_val({tag, "_fwd_rt"}, fwd_rt_data, model_fwd(ex_rt, ex_rt_data));
        check_val({tag, "_stall"}, {31'd0, stall}, {31'd0, model_stall()});
        check_val({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, hist[1].we && hist[1].rd != 5'd0});
        check_val({tag, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, hist[1].rd});
        check_val({tag, "_wb_data"}, wb_data, hist[1].val);
        check_val({tag, "_stall_count"}, {16'd0, stall_count},
                  (model_cnt > 65535) ? 32'h0000FFFF : model_cnt);
    endtask

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic tick();
        logic s;
        @(posedge clk);
        if (rst_n) begin
            s = model_stall();
            hist[1] = '{rd: hist[0].rd, we: hist[0].we, load: 1'b0,
                        val: hist[0].load ? mem_load_data : hist[0].val};
            hist[0] = '{rd: ex_rd, we: ex_reg_write, load: ex_mem_read, val: ex_alu_result};
            if (s) model_cnt++;
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic we, input logic ld,
                            input logic [31:0] res, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] rs_d, input logic [31:0] rt_d);
        ex_rd = rd; ex_reg_write = we; ex_mem_read = ld; ex_alu_result = res;
        ex_rs = rs; ex_rt = rt; ex_rs_data = rs_d; ex_rt_data = rt_d;
        id_rs = 5'd0; id_rt = 5'd0;
        #1;
    endtask

    task automatic drive_nop();
        drive_ex(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    int cnt0;

    initial begin
        rst_n = 1'b0;
        mem_load_data = 32'd0;
        drive_nop();
        model_reset();
        #1;
        check_all("reset");
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        check_all("post_reset");

`ifdef WB_FWD_BYPASS_EN
        // Forward from M
        drive_ex(5'd5, 1'b1, 1'b0, 32'h11, 5'd0, 5'd0, 32'd0, 32'd0);
        check_all("m_fwd_a"); tick();
        drive_ex(5'd0, 1'b0, 1'b0, 32'd0, 5'd5, 5'd0, 32'hCAFE, 32'd0);
        check_all("m_fwd_b");
        check_val("m_fwd_value", fwd_rs_data, 32'h11);
        tick();

        // Forward from W after one independent instruction
        drive_ex(5'd5, 1'b1, 1'b0, 32'h22, 5'd0, 5'd0, 32'd0, 32'd0); tick();
        drive_ex(5'd6, 1'b1, 1'b0, 32'h99, 5'd0, 5'd0, 32'd0, 32'd0); tick();
        drive_ex(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd5, 32'd0, 32'hBEEF);
        check_all("w_fwd");
        check_val("w_fwd_value", fwd_rt_data, 32'h22);
        check_val("w_fwd_wb_we", {31'd0, wb_we}, 32'd1);
        check_val("w_fwd_wb_addr", {27'd0, wb_addr}, 32'd5);
        tick();

        // Load-use: one stall cycle, then forward the loaded value from W
        cnt0 = model_cnt;
        drive_ex(5'd7, 1'b1, 1'b1, 32'h100, 5'd0, 5'd0, 32'd0, 32'd0);
        id_rs = 5'd7; #1;
        check_all("ld_use_a");
        check_val("ld_use_stall", {31'd0, stall}, 32'd1);
        tick();
        drive_nop();
        mem_load_data = 32'hDEAD; #1;
        check_all("ld_use_bubble");
        check_val("ld_use_stall_clear", {31'd0, stall}, 32'd0);
        tick();
        mem_load_data = 32'd0;
        drive_ex(5'd0, 1'b0, 1'b0, 32'd0, 5'd7, 5'd0, 32'h1, 32'd0);
        check_all("ld_use_c");
        check_val("ld_use_value", fwd_rs_data, 32'hDEAD);
        check_val("ld_use_count", {16'd0, stall_count}, cnt0 + 1);
        tick();

        // Register zero is never forwarded nor written
        drive_ex(5'd0, 1'b1, 1'b0, 32'h55, 5'd0, 5'd0, 32'd0, 32'd0); tick();
        drive_ex(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        check_val("r0_fwd_m", fwd_rs_data, 32'd0);
        tick();
        check_all("r0_wb");
        check_val("r0_wb_we", {31'd0, wb_we}, 32'd0);
        tick();
`else
        // No bypass: a dependent instruction waits three cycles for the register file
        cnt0 = model_cnt;
        drive_ex(5'd4, 1'b1, 1'b0, 32'h44, 5'd0, 5'd0, 32'd0, 32'd0);
        id_rs = 5'd4; #1;
        for (int c = 0; c < 3; c++) begin
            check_all("nobyp_hold");
            check_val("nobyp_stall", {31'd0, stall}, 32'd1);
            tick();
            drive_nop();
            id_rs = 5'd4; #1;
        end
        check_all("nobyp_release");
        check_val("nobyp_stall_clear", {31'd0, stall}, 32'd0);
        check_val("nobyp_count", {16'd0, stall_count}, cnt0 + 3);
        tick();
        drive_ex(5'd0, 1'b0, 1'b0, 32'd0, 5'd4, 5'd0, 32'h44, 32'd0);
        check_all("nobyp_use");
        check_val("nobyp_value", fwd_rs_data, 32'h44);
        tick();
`endif

        // M and W both hold r3: youngest wins, then reset mid-sequence
        drive_ex(5'd3, 1'b1, 1'b0, 32'hB, 5'd0, 5'd0, 32'd0, 32'd0); tick();
        drive_ex(5'd3, 1'b1, 1'b0, 32'hA, 5'd0, 5'd0, 32'd0, 32'd0); tick();
        drive_ex(5'd0, 1'b0, 1'b0, 32'd0, 5'd3, 5'd0, 32'h1234, 32'd0);
        check_all("mw_pri");
`ifdef WB_FWD_BYPASS_EN
        check_val("mw_pri_value", fwd_rs_data, 32'hA);
`endif
        check_val("mw_pri_wb_we", {31'd0, wb_we}, 32'd1);
        rst_n = 1'b0; #1;
        model_reset();
        check_all("async_rst");
        check_val("async_rst_wb_we", {31'd0, wb_we}, 32'd0);
        check_val("async_rst_fwd", fwd_rs_data, 32'h1234);
        tick();
        #2 rst_n = 1'b1;
        check_all("rst_release_pre");
        tick();
        check_all("rst_release_post");

        // Saturation of the stall counter under a permanent hazard
        drive_ex(5'd1, 1'b1, 1'b1, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        id_rs = 5'd1; #1;
        for (int c = 0; c < 65540; c++) tick();
        check_all("sat");
        check_val("sat_value", {16'd0, stall_count}, 32'h0000FFFF);
        rst_n = 1'b0; #1;
        model_reset();
        drive_nop();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Random traffic over a small register window so hazards are frequent
        for (int c = 0; c < 400; c++) begin
            ex_rd         = 5'($urandom_range(0, 7));
            ex_reg_write  = 1'($urandom_range(0, 1));
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            ex_alu_result = $urandom;
            ex_rs         = 5'($urandom_range(0, 7));
            ex_rt         = 5'($urandom_range(0, 7));
            ex_rs_data    = $urandom;
            ex_rt_data    = $urandom;
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            mem_load_data = $urandom;
            #1;
            check_all("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_forward_unit.md
WRITEBACK_FORWARD_UNIT -- requirements
Module: writeback_forward_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port ex_rd, input, 5: destination register of the instruction in EX.
REQ-004 SHALL have port ex_reg_write, input, 1: EX instruction writes a register.
REQ-005 SHALL have port ex_mem_read, input, 1: EX instruction is a load.
REQ-006 SHALL have port ex_alu_result, input, 32: EX ALU result.
REQ-007 SHALL have port ex_rs / ex_rt, input, 5 each: source register numbers of the EX instruction.
REQ-008 SHALL have port ex_rs_data / ex_rt_data, input, 32 each: register-file values latched in ID/EX.
REQ-009 SHALL have port id_rs / id_rt, input, 5 each: source register numbers of the ID instruction.
REQ-010 SHALL have port mem_load_data, input, 32: data memory read data for the M-stage instruction.
REQ-011 SHALL have port fwd_rs_data / fwd_rt_data, output, 32 each: resolved EX operands; fwd_rt_data drives the ALU source mux register leg.
REQ-012 SHALL have port stall, output, 1: hold PC and IF/ID, bubble ID/EX.
REQ-013 SHALL have ports wb_we (1), wb_addr (5), wb_data (32), outputs: register-file write port.
REQ-014 SHALL have port stall_count, output, 16: saturating count of stall cycles.

Function
REQ-015 M stage register {m_rd, m_we, m_load, m_result} SHALL capture {ex_rd, ex_reg_write, ex_mem_read, ex_alu_result} every clk edge.
REQ-016 W stage register {w_rd, w_we, w_data} SHALL capture {m_rd, m_we, m_load ? mem_load_data : m_result} every clk edge.
REQ-017 wb_we/wb_addr/wb_data SHALL equal w_we/w_rd/w_data, with wb_we forced 0 when w_rd == 0.
REQ-018 Operand resolution, per source, in priority order: (a) source == 0 -> ex_*_data unchanged; (b) m_we && !m_load && m_rd == source -> m_result; (c) w_we && w_rd == source -> w_data; (d) otherwise ex_*_data.
REQ-019 Forwarding outputs SHALL be combinational; zero cycle latency.
REQ-020 Load-use: stall SHALL be 1 combinationally when ex_mem_read && ex_reg_write && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt); otherwise 0.
REQ-021 During stall, the M stage SHALL still capture EX. The external pipeline bubbles ID/EX, so the load reaches W and is forwarded by rule (c) on the following cycle.
REQ-022 A load in M matching an EX source SHALL NOT be forwarded by rule (b). REQ-020 guarantees this case never reaches EX.
REQ-023 stall_count SHALL increment on each clk edge with stall == 1 and SHALL saturate at 16'hFFFF, with no wrap.
REQ-024 If M and W both match the same source, M SHALL win (youngest value).

Reset
REQ-025 rst_n low SHALL immediately clear all M/W fields and stall_count to 0. wb_we = 0, wb_addr = 0, wb_data = 0.
REQ-026 During and after reset, fwd_*_data SHALL equal ex_*_data until valid stages load. An in-flight load or forward is discarded.
REQ-027 Deassertion SHALL take effect at the first clk edge after rst_n rises.

Configuration
REQ-028 Macro WB_FWD_BYPASS_EN defined: rules REQ-018/020/021 apply as written.
REQ-029 Macro WB_FWD_BYPASS_EN undefined: fwd_*_data = ex_*_data always. stall SHALL be 1 when any nonzero id_rs/id_rt matches a writing rd in EX, M or W. This stalls until the value is written into the register file; worst case is 3 consecutive stall cycles per hazard.

Verification
REQ-030 EX: rd=5, we=1, result=0x11; next cycle EX rs=5 -> fwd_rs_data=0x11 via M.
REQ-031 Write r5=0x22, one independent instruction, then EX rt=5 -> fwd_rt_data=0x22 via W; same cycle wb_we=1, wb_addr=5.
REQ-032 Load r7 (mem_load_data=0xDEAD) in EX with id_rs=7 -> stall=1 exactly one cycle, stall_count=1; next EX rs=7 -> fwd_rs_data=0xDEAD.
REQ-033 EX writes r0=0x55 then EX rs=0 with ex_rs_data=0 -> fwd_rs_data=0, wb_we=0 at write-back.
REQ-034 M holds r3=0xA, W holds r3=0xB, EX rs=3 -> fwd_rs_data=0xA; assert rst_n=0 mid-sequence -> wb_we=0 and fwd_rs_data=ex_rs_data immediately.
REQ-035 Without WB_FWD_BYPASS_EN: r4 write followed by dependent id_rs=4 -> stall held 3 cycles, fwd_rs_data equals register-file value.
